// File: rtl/sync_pulse_multi_if.sv
// ============================================================================
// Module      : sync_pulse_multi_if
// Description : Signal bundle for sync_pulse_multi. Carries the asynchronous
//               event inputs, the overflow clear strobes and the per-channel
//               pulse / busy / overflow outputs.
//                 sig_in    - asynchronous event inputs, one bit per channel
//                 ovf_clr   - write-1-to-clear strobes for ovf (clk domain)
//                 pulse_out - stretched event pulses
//                 busy      - channel is emitting a pulse or sitting in a gap
//                 ovf       - sticky "event dropped" flags
//               master: event source / status consumer side
//               slave : synchronizer side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sync_pulse_multi_if #(
  parameter int CH = 4
);
  logic [CH-1:0] sig_in;
  logic [CH-1:0] ovf_clr;
  logic [CH-1:0] pulse_out;
  logic [CH-1:0] busy;
  logic [CH-1:0] ovf;

  modport master (
    output sig_in,
    output ovf_clr,
    input  pulse_out,
    input  busy,
    input  ovf
  );

  modport slave (
    input  sig_in,
    input  ovf_clr,
    output pulse_out,
    output busy,
    output ovf
  );
endinterface

`default_nettype wire

// File: rtl/sync_pulse_multi.sv
// ============================================================================
// Module      : sync_pulse_multi
// Description : Multi-channel event synchronizer. Each channel passes its
//               asynchronous input through a SYNC_STAGES-deep flop chain,
//               detects rising / falling / both edges (MODE) and turns every
//               accepted event into a pulse exactly STRETCH cycles wide.
//               RETRIGGER=0 queues one pending event (emitted after a one
//               cycle low gap) and flags further events in ovf; RETRIGGER=1
//               restarts the width counter instead.
// Ports       : clk  - clock, all state changes on the rising edge
//               rst  - synchronous active-high reset
//               bus  - sync_pulse_multi_if.slave
//                        sig_in, ovf_clr in; pulse_out, busy, ovf out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_pulse_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int STRETCH     = 1,
  parameter int RETRIGGER   = 0
) (
  input  wire                    clk,
  input  wire                    rst,
  sync_pulse_multi_if.slave      bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  localparam logic [7:0] RELOAD = 8'(STRETCH - 1);

  logic [CH-1:0] pulse_vec;
  logic [CH-1:0] busy_vec;
  logic [CH-1:0] ovf_vec;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic [7:0]             cnt;
    logic [7:0]             cnt_nxt;
    logic                   pend;
    logic                   pend_nxt;
    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic                   ovf_q;
    logic                   ovf_set;
    logic                   pulse_q;
    logic                   busy_q;
    logic                   rise;
    logic                   fall;
    logic                   ev;

    // Edge detection works purely on registered values: the last sync
    // stage against its one-cycle-old copy.
    always_comb begin
      rise = sync_q[SYNC_STAGES-1] & ~prev;
      fall = ~sync_q[SYNC_STAGES-1] & prev;
      if (MODE == 0)      ev = rise;
      else if (MODE == 1) ev = fall;
      else                ev = rise | fall;
    end

    // State register plus the registered outputs derived from next state,
    // so pulse_out and busy come straight from flops.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q  <= '0;
        prev    <= 1'b0;
        cnt     <= 8'd0;
        pend    <= 1'b0;
        state   <= IDLE;
        ovf_q   <= 1'b0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.sig_in[i]};
        prev    <= sync_q[SYNC_STAGES-1];
        cnt     <= cnt_nxt;
        pend    <= pend_nxt;
        state   <= state_nxt;
        // A drop in the same cycle as a clear strobe keeps the flag set.
        ovf_q   <= ovf_set | (ovf_q & ~bus.ovf_clr[i]);
        pulse_q <= (state_nxt == ACTIVE);
        busy_q  <= (state_nxt != IDLE);
      end
    end

    // Next-state logic.
    always_comb begin
      state_nxt = state;
      case (state)
        IDLE: begin
          if (ev) state_nxt = ACTIVE;
        end
        ACTIVE: begin
          if (cnt == 8'd0) begin
            if (RETRIGGER != 0) begin
              // A last-cycle event extends the pulse without a break.
              state_nxt = ev ? ACTIVE : IDLE;
            end else begin
              // This cycle's event counts as pending for the exit decision.
              state_nxt = (pend | ev) ? GAP : IDLE;
            end
          end
        end
        GAP: begin
          state_nxt = ACTIVE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    // Width counter, pending flag and overflow detection.
    always_comb begin
      cnt_nxt  = cnt;
      pend_nxt = pend;
      ovf_set  = 1'b0;
      case (state)
        IDLE: begin
          if (ev) cnt_nxt = RELOAD;
        end
        ACTIVE: begin
          if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
          if (ev) begin
            if (RETRIGGER != 0) cnt_nxt = RELOAD;
            else if (pend)      ovf_set = 1'b1;
            else                pend_nxt = 1'b1;
          end
        end
        GAP: begin
          // The queued event is consumed on exit; a new event arriving in
          // the gap becomes the next pending one.
          cnt_nxt  = RELOAD;
          pend_nxt = ev;
        end
        default: begin
          cnt_nxt  = 8'd0;
          pend_nxt = 1'b0;
        end
      endcase
    end

    assign pulse_vec[i] = pulse_q;
    assign busy_vec[i]  = busy_q;
    assign ovf_vec[i]   = ovf_q;
  end

  assign bus.pulse_out = pulse_vec;
  assign bus.busy      = busy_vec;
  assign bus.ovf       = ovf_vec;

endmodule

`default_nettype wire

// File: doc/sync_pulse_multi.md
# sync_pulse_multi

Multi-channel single-clock event synchronizer. It brings CH asynchronous inputs into the `clk` domain through a SYNC_STAGES-deep flop chain and detects edges according to MODE. Each detected event becomes an output pulse exactly STRETCH cycles wide, with pending-event queueing or retrigger behaviour and a sticky overflow flag. It is the parametrised successor of the team's two-flop pulse synchronizer and sits at the boundary between unclocked or foreign-clock event sources and fabric logic running on `clk`.

## Interface
Parameters:
- CH, default 4: number of independent channels (1..32).
- SYNC_STAGES, default 2: synchronizer depth (2..4).
- MODE, default 0: edge select. 0 = rising, 1 = falling, 2 = both. Applies to all channels.
- STRETCH, default 1: output pulse width in `clk` cycles (1..255).
- RETRIGGER, default 0: behaviour on an event during an active pulse. 0 = queue one pending event; 1 = reload the width counter.

Ports:
- clk, input, 1: single clock. Everything is registered on the rising edge.
- rst, input, 1: reset. Synchronous and active-high, sampled on the rising edge of `clk`.
- sig_in, input, CH: asynchronous event inputs, one bit per channel.
- ovf_clr, input, CH: write-1-to-clear strobe for `ovf`, synchronous to `clk`.
- pulse_out, output, CH: registered, stretched event pulses.
- busy, output, CH: registered. High while the channel is in ACTIVE or GAP.
- ovf, output, CH: registered sticky flag. Set when an event was dropped.

## Operation
- Each channel has:
  - a sync chain s[0..SYNC_STAGES-1];
  - a history flop `prev`, which captures s[last];
  - an 8-bit width counter `cnt`;
  - a `pend` flag;
  - a 2-bit state: IDLE, ACTIVE, GAP.
- Event definition, combinational from registered values:
  - rise = s[last] & ~prev
  - fall = ~s[last] & prev
  - ev = rise (MODE 0), fall (MODE 1), or rise|fall (MODE 2)
- IDLE, on ev: go to ACTIVE, cnt <= STRETCH-1.
- ACTIVE, cnt != 0: cnt decrements each cycle.
  - RETRIGGER=1: ev reloads cnt <= STRETCH-1.
  - RETRIGGER=0: ev with pend=0 sets pend. ev with pend=1 is dropped and sets ovf.
- ACTIVE, cnt == 0, evaluated with pend including this cycle's ev:
  - pend=1: go to GAP.
  - pend=0: go to IDLE.
  - RETRIGGER=1: ev in this cycle reloads cnt instead and the channel stays ACTIVE.
- GAP: lasts exactly 1 cycle with pulse_out=0, so back-to-back pulses stay distinguishable. On exit: go to ACTIVE, cnt <= STRETCH-1, pend cleared.
  - ev during GAP sets pend again; set wins over the simultaneous clear.
- pulse_out = (state == ACTIVE), registered.
- ovf: set and ovf_clr in the same cycle leaves ovf = 1 (set wins). Clear acts on the next edge.
- Channels are fully independent. There is no cross-channel arbitration.

## Timing
- Reset (rst=1 at a rising edge) forces, on that edge, regardless of sig_in:
  - all s[] = 0, prev = 0, cnt = 0, pend = 0, state = IDLE;
  - pulse_out = 0, busy = 0, ovf = 0.
- Reset mid-pulse aborts the pulse and discards pend.
- An input held high through reset release is a rising event once it propagates through the chain.
- Latency: let sig_in change settle before rising edge E0, which samples it into s[0]. s[last] holds it after edge E0+SYNC_STAGES-1, and pulse_out rises after edge E0+SYNC_STAGES. That is 3 edges from sampling to pulse_out for SYNC_STAGES=2.
- Width: pulse_out is high for exactly STRETCH cycles per accepted event (RETRIGGER=0).
- Queued event: 1-cycle low GAP, then another STRETCH-cycle pulse.
- Input pulses shorter than one `clk` period may be missed. Pulses held for ≥2 cycles are always seen.
- In MODE 2, the input must stay stable for ≥1 cycle between edges to yield separate events.

## Test plan
- Reset and basic latency: SYNC_STAGES=2, STRETCH=1. Hold rst for 2 cycles, then raise sig_in[0] at cycle 5 → pulse_out[0]=1 for exactly 1 cycle, 3 edges after sampling. busy[0] matches. Other channels stay 0.
- Stretch: STRETCH=4, MODE=0. Send a 10-cycle-high input on ch1 → pulse_out[1] high for 4 cycles. No pulse on the falling edge.
- Pending and overflow: STRETCH=8, RETRIGGER=0. Three rising events on ch2, 3 cycles apart → one 8-cycle pulse, then 1 low cycle, then a second 8-cycle pulse. The third event is dropped and ovf[2]=1. ovf_clr[2]=1 → ovf[2]=0 next cycle. Set and clear in the same cycle → ovf stays 1.
- Retrigger: STRETCH=5, RETRIGGER=1. Events at t and t+3 on ch0 → one continuous pulse 8 cycles long. ovf stays 0.
- Both-edge mode: MODE=2, STRETCH=1. sig_in[3] high for 4 cycles, then low → two 1-cycle pulses, 4 cycles apart.
- Reset mid-operation: assert rst during an ACTIVE pulse with pend set → next edge gives pulse_out=0, busy=0, ovf=0. With sig_in held high across release, exactly one new pulse appears SYNC_STAGES+1 edges later.
